mem_addr_seq: RTL
=================

MEM_ADDR_SEQ -- requirements
Module: mem_addr_seq

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 32, address and data width.
- NUM_SRC, 4, number of normal address sources.
- NUM_VEC, 3, number of exception vectors.
- VEC_BASE, 253, address of vector 0.
- MEM_LAT, 1, read latency of memory in cycles (>=1).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 src_data  in  NUM_SRC*WIDTH  packed normal address sources; source i at bits [i*WIDTH +: WIDTH].
REQ-005 src_sel  in  clog2(NUM_SRC)  normal source select.
REQ-006 pc_in  in  WIDTH  current PC, saved as EPC when an exception is accepted.
REQ-007 exc_req  in  1  exception request, sampled each cycle.
REQ-008 exc_cause  in  clog2(NUM_VEC)+1  exception cause index.
REQ-009 mem_rdata  in  8  memory read byte holding the handler address.
REQ-010 addr_out  out  WIDTH  registered memory address.
REQ-011 busy  out  1  high when the FSM is not in IDLE.
REQ-012 handler_pc  out  WIDTH  zero-extended handler address.
REQ-013 handler_valid  out  1  one-cycle strobe qualifying handler_pc.
REQ-014 epc  out  WIDTH  saved PC of the accepted exception.
REQ-015 exc_err  out  1  one-cycle error strobe.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE, addr_out SHALL load src_data[src_sel] each cycle, giving one cycle of latency.
REQ-018 In IDLE, if src_sel >= NUM_SRC, addr_out SHALL load 0.
REQ-019 In IDLE with exc_req=1, the block SHALL latch the cause, set epc<=pc_in and move to ISSUE.
REQ-020 In ISSUE, addr_out SHALL be VEC_BASE+cause and the FSM SHALL move to WAIT with a counter loaded to MEM_LAT-1.
REQ-021 In WAIT, addr_out SHALL hold its value; the counter SHALL decrement each cycle, and the FSM SHALL move to DONE when the counter is 0.
REQ-022 On entry to DONE, the block SHALL set handler_pc <= {0, mem_rdata}, zero-extended to WIDTH.
REQ-023 In DONE, handler_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-024 handler_pc SHALL hold its value until the next DONE.
REQ-025 Total latency from exc_req accepted to handler_valid SHALL be MEM_LAT+2 cycles.
REQ-026 If exc_cause >= NUM_VEC, the block SHALL use vector NUM_VEC-1 and pulse exc_err in the cycle after acceptance.
REQ-027 If exc_req arrives while busy, handling SHALL follow the Configuration section.
REQ-028 The block SHALL tie busy to (state != IDLE).
REQ-029 epc SHALL change only on acceptance of an exception.

Reset
REQ-030 On reset=0, asynchronously, the block SHALL force:
- state to IDLE,
- addr_out, handler_pc and epc to 0,
- handler_valid, exc_err and busy to 0,
- all pending state to clear.
REQ-031 Reset asserted mid-exception SHALL abort the exception with no handler_valid.
REQ-032 After reset deassertion, the first rising edge SHALL behave as in IDLE.

Configuration
REQ-033 The macro MEM_ADDR_SEQ_PENDING_EN SHALL select how exc_req is handled while busy.
REQ-034 Without MEM_ADDR_SEQ_PENDING_EN, exc_req while busy SHALL be dropped and SHALL pulse exc_err the next cycle.
REQ-035 With MEM_ADDR_SEQ_PENDING_EN, exc_req while busy SHALL be stored, with cause and pc_in, in a one-deep pending slot.
REQ-036 With MEM_ADDR_SEQ_PENDING_EN, the pending slot SHALL be serviced from IDLE before any new exc_req; the new exc_req SHALL then itself be treated as arriving while busy.
REQ-037 With MEM_ADDR_SEQ_PENDING_EN, exc_req while the slot is full SHALL be dropped with an exc_err pulse.

Verification
REQ-038 Normal path: src_data = {40, 30, 20, 10}, src_sel=2 -> addr_out=30 one cycle later; busy=0.
REQ-039 Exception: exc_cause=1, pc_in=0x100, mem_rdata=0x80, MEM_LAT=1 -> addr_out=254, then handler_pc=0x80 with handler_valid 3 cycles after request; epc=0x100.
REQ-040 Bad cause: exc_cause=3 -> addr_out=255 and an exc_err pulse.
REQ-041 Busy request: second exc_req in WAIT -> without the macro, one exc_err pulse and no second handler_valid; with the macro, a second handler_valid 3 cycles after the first DONE.
REQ-042 Reset mid-exception: reset=0 during WAIT -> all outputs 0 immediately; no handler_valid afterwards.
REQ-043 MEM_LAT=3 with exc_cause=0 -> addr_out=253 held for 3 cycles; handler_valid 5 cycles after request.

Source files
------------

// File: rtl/mem_addr_seq.sv
// mem_addr_seq: registered memory-address mux with an exception-vector fetch sequencer.
// Optional feature: define MEM_ADDR_SEQ_PENDING_EN to hold one exception request that
// arrives while busy and service it on return to IDLE (otherwise such requests are dropped).
module mem_addr_seq #(
    parameter int WIDTH    = 32,
    parameter int NUM_SRC  = 4,
    parameter int NUM_VEC  = 3,
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1,
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CW = $clog2(NUM_VEC) + 1,
    localparam int KW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SW-1:0]            src_sel,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic                     exc_req,
    input  logic [CW-1:0]            exc_cause,
    input  logic [7:0]               mem_rdata,
    output logic [WIDTH-1:0]         addr_out,
    output logic                     busy,
    output logic [WIDTH-1:0]         handler_pc,
    output logic                     handler_valid,
    output logic [WIDTH-1:0]         epc,
    output logic                     exc_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cause;
    logic [KW-1:0]    cnt;
    logic [WIDTH-1:0] srcs [NUM_SRC];
    logic [WIDTH-1:0] src_word;
`ifdef MEM_ADDR_SEQ_PENDING_EN
    logic             pend_v;
    logic [CW-1:0]    pend_cause;
    logic [WIDTH-1:0] pend_pc;
`endif

    function automatic logic bad(input logic [CW-1:0] c);
        return int'(c) >= NUM_VEC;
    endfunction

    // out-of-range causes fall back to the last vector
    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] c);
        return bad(c) ? CW'(NUM_VEC - 1) : c;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign srcs[i] = src_data[i*WIDTH +: WIDTH];
    end

    assign src_word = (int'(src_sel) < NUM_SRC) ? srcs[src_sel] : '0;
    assign busy     = (state != IDLE);

    // sequencer: address mux in IDLE, vector fetch through ISSUE/WAIT/DONE, busy-request policy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cause         <= '0;
            cnt           <= '0;
            addr_out      <= '0;
            handler_pc    <= '0;
            handler_valid <= 1'b0;
            epc           <= '0;
            exc_err       <= 1'b0;
`ifdef MEM_ADDR_SEQ_PENDING_EN
            pend_v        <= 1'b0;
            pend_cause    <= '0;
            pend_pc       <= '0;
`endif
        end else begin
            handler_valid <= 1'b0;
            exc_err       <= 1'b0;
            case (state)
                IDLE: begin
                    addr_out <= src_word;
`ifdef MEM_ADDR_SEQ_PENDING_EN
                    if (pend_v) begin
                        cause      <= clamp(pend_cause);
                        epc        <= pend_pc;
                        exc_err    <= bad(pend_cause);
                        state      <= ISSUE;
                        pend_v     <= exc_req;
                        pend_cause <= exc_cause;
                        pend_pc    <= pc_in;
                    end else
`endif
                    if (exc_req) begin
                        cause   <= clamp(exc_cause);
                        epc     <= pc_in;
                        exc_err <= bad(exc_cause);
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    addr_out <= WIDTH'(VEC_BASE) + WIDTH'(cause);
                    cnt      <= KW'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        handler_pc    <= WIDTH'(mem_rdata);
                        handler_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
            if (exc_req && state != IDLE) begin
`ifdef MEM_ADDR_SEQ_PENDING_EN
                if (!pend_v) begin
                    pend_v     <= 1'b1;
                    pend_cause <= exc_cause;
                    pend_pc    <= pc_in;
                end else begin
                    exc_err <= 1'b1;
                end
`else
                exc_err <= 1'b1;
`endif
            end
        end
    end
endmodule
